// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Stall/bubble controller for the 5-stage pipeline. It compares the D-stage
// operand needs (Tuse) with the in-flight producers in E and M (Tnew). It also
// tracks the multi-cycle multiply/divide unit with a busy-count FSM. When a
// stall is needed, it holds the PC and the F-to-D register, and it loads a
// bubble into the D-to-E register. The E-to-M and M-to-W registers are never
// held by this block.
//
// Parameters:
//   MULT_LAT  busy cycles after a mult/multu start
//   DIV_LAT   busy cycles after a div/divu start
//   CNT_W     busy counter width (must hold max(MULT_LAT, DIV_LAT))
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   D_rs, D_rt          source register numbers of the D-stage instruction
//   D_tuse_rs/rt        cycles until D needs the operand (3 = unused)
//   D_is_md             D instruction uses the mult/div unit
//   E_wa, E_tnew        E-stage destination and cycles until its result is ready
//   M_wa, M_tnew        M-stage destination and cycles until its result is ready
//   E_md_start/E_md_div mult/div start in E (div = 1 selects the divide latency)
//   F_pause, D_pause    hold PC / F-to-D register
//   E_flush             insert a bubble into the D-to-E register
//   md_busy             mult/div unit occupied
//   stall_cycles        (only with STALL_CNT_EN) saturating count of stall cycles
//
// Optional feature macro: STALL_CNT_EN
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_is_md,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_div,
    output logic       F_pause,
    output logic       D_pause,
    output logic       E_flush,
    output logic       md_busy
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    assign md_busy = (state_q == BUSY);

    // Register 0 is never a real dependency. The W stage is always forwarded,
    // so only producers in E and M whose result is still too late can stall.
    always_comb begin
        stall_rs = (D_rs != 5'd0) &&
                   (((D_rs == E_wa) && (E_tnew > D_tuse_rs)) ||
                    ((D_rs == M_wa) && (M_tnew > D_tuse_rs)));
        stall_rt = (D_rt != 5'd0) &&
                   (((D_rt == E_wa) && (E_tnew > D_tuse_rt)) ||
                    ((D_rt == M_wa) && (M_tnew > D_tuse_rt)));
        // A mult/div start in E already occupies the unit for D's purposes.
        stall_md = D_is_md && (md_busy || E_md_start);
        stall    = !reset && (stall_rs || stall_rt || stall_md);
    end

    assign F_pause = stall;
    assign D_pause = stall;
    assign E_flush = stall;

    // Busy-count FSM. A start while BUSY is a protocol violation. It is ignored
    // so that the counter keeps running the operation already in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (E_md_start) begin
                    cnt_d   = E_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of the cycles in which the pipeline was stalled.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
